// File: rtl/switch_input_port_if.sv
// CPU-side read bus of the switch input port: one-cycle registered read handshake.
interface switch_input_port_if;
  logic        rd;
  logic [3:0]  addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output rd, output addr, input rd_data, input rd_valid);
  modport slave  (input rd, input addr, output rd_data, output rd_valid);
endinterface

// File: rtl/switch_input_port.sv
// Switch input port: 2-flop sync plus per-bit debounce (DEBOUNCE_CYCLES+2 edges to level), sticky rise bits, change counter.
// Reads are accepted every cycle with no backpressure; rd_data/rd_valid are registered one edge after rd.
module switch_input_port #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  switch,
  switch_input_port_if.slave bus,
  output logic [WIDTH-1:0]  level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1_q, sync1_d;
  logic [WIDTH-1:0]         sync2_q, sync2_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         level_q, level_d;
  logic [WIDTH-1:0]         edges_q, edges_d;
  logic [15:0]              chg_count_q, chg_count_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;

  logic [WIDTH-1:0]         new_rises;
  logic [31:0]              reg_val;
  logic [1:0]               unused_addr;

  assign unused_addr = bus.addr[1:0];

  always_comb begin
    sync1_d = switch;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    new_rises   = level_d & ~level_q;
    chg_count_d = chg_count_q;
    if (level_d != level_q) begin
      chg_count_d = chg_count_q + 16'd1;
    end

    // Register values are taken from pre-edge state so a coincident update is not visible.
    reg_val = '0;
    case (bus.addr[3:2])
      2'd0:    reg_val[WIDTH-1:0] = level_q;
      2'd1:    reg_val[WIDTH-1:0] = edges_q;
      2'd2:    reg_val[15:0]      = chg_count_q;
      default: reg_val            = '0;
    endcase

    // Clear-on-read keeps any rise landing on the read edge pending for the next read.
    if (bus.rd && (bus.addr[3:2] == 2'd1)) begin
      edges_d = new_rises;
    end else begin
      edges_d = edges_q | new_rises;
    end

    rd_valid_d = bus.rd;
    rd_data_d  = bus.rd ? reg_val : rd_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      edges_q     <= '0;
      chg_count_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      edges_q     <= edges_d;
      chg_count_q <= chg_count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign level        = level_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Bench for switch_input_port: vector table, directed corner sequences, random run against a reference model, counter wrap on a D=2 build.
module tb_switch_input_port;

  localparam int D = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw    = '0;
  logic [7:0] level;
  logic [1:0] sw2   = '0;
  logic [1:0] level2;

  switch_input_port_if bus ();
  switch_input_port_if bus2 ();

  switch_input_port #(.WIDTH(8), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .switch(sw), .bus(bus), .level(level)
  );

  switch_input_port #(.WIDTH(2), .DEBOUNCE_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .switch(sw2), .bus(bus2), .level(level2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: level follows the synchronized switch once the last D samples all disagree with it.
  logic [7:0]  m_s1 = '0, m_s2 = '0, m_level = '0, m_edges = '0;
  logic [15:0] m_cnt = '0;
  logic [31:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0;
  logic [7:0]  s2_hist[$];

  initial forever begin
    logic [7:0]  nl, rises;
    logic [31:0] sel;
    logic        stable;
    @(posedge clock);
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_edges = '0; m_cnt = '0;
      m_rd_data = '0; m_rd_valid = 1'b0;
      s2_hist.delete();
    end else begin
      case (bus.addr[3:2])
        2'd0:    sel = {24'd0, m_level};
        2'd1:    sel = {24'd0, m_edges};
        2'd2:    sel = {16'd0, m_cnt};
        default: sel = 32'd0;
      endcase
      s2_hist.push_back(m_s2);
      if (s2_hist.size() > D) void'(s2_hist.pop_front());
      nl = m_level;
      if (s2_hist.size() == D) begin
        for (int b = 0; b < 8; b++) begin
          stable = 1'b1;
          foreach (s2_hist[k]) if (s2_hist[k][b] == m_level[b]) stable = 1'b0;
          if (stable) nl[b] = m_s2[b];
        end
      end
      rises = nl & ~m_level;
      if (nl != m_level) m_cnt = m_cnt + 16'd1;
      if (bus.rd && bus.addr[3:2] == 2'd1) m_edges = rises;
      else m_edges = m_edges | rises;
      if (bus.rd) m_rd_data = sel;
      m_rd_valid = bus.rd;
      m_level = nl;
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  typedef struct {
    logic [7:0]  sw;
    int          cycles;
    logic [3:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus.rd   = 1'b1;
    bus.addr = a;
    @(negedge clock);
    d = bus.rd_data;
    v = bus.rd_valid;
    bus.rd = 1'b0;
  endtask

  task automatic do_read2(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus2.rd   = 1'b1;
    bus2.addr = a;
    @(negedge clock);
    d = bus2.rd_data;
    v = bus2.rd_valid;
    bus2.rd = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        v;

    vt[0]  = '{8'h00, 5,  4'h0, 32'h0000_0000};
    vt[1]  = '{8'h05, 20, 4'h0, 32'h0000_0005};
    vt[2]  = '{8'h05, 0,  4'h8, 32'h0000_0001};
    vt[3]  = '{8'h05, 0,  4'h4, 32'h0000_0005};
    vt[4]  = '{8'h05, 0,  4'h4, 32'h0000_0000};
    vt[5]  = '{8'h00, 20, 4'h8, 32'h0000_0002};
    vt[6]  = '{8'h00, 0,  4'h4, 32'h0000_0000};
    vt[7]  = '{8'hF0, 20, 4'h1, 32'h0000_00F0};
    vt[8]  = '{8'hF0, 0,  4'hC, 32'h0000_0000};
    vt[9]  = '{8'hF0, 0,  4'h4, 32'h0000_00F0};
    vt[10] = '{8'h0F, 20, 4'hB, 32'h0000_0004};
    vt[11] = '{8'h0F, 0,  4'h6, 32'h0000_000F};
    vt[12] = '{8'h0F, 0,  4'h7, 32'h0000_0000};
    vt[13] = '{8'h0F, 0,  4'h2, 32'h0000_000F};

    bus.rd = 1'b0;  bus.addr = '0;
    bus2.rd = 1'b0; bus2.addr = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset_rd_data", bus.rd_data, 32'h0);
    chk("reset_level2", 32'(level2), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      sw = vt[i].sw;
      repeat (vt[i].cycles) @(negedge clock);
      do_read(vt[i].addr, d, v);
      chk($sformatf("vec%0d_data", i), d, vt[i].exp);
      chk($sformatf("vec%0d_valid", i), 32'(v), 32'h1);
    end

    // Latency: level changes on exactly the 18th edge after the switch moves.
    sw = 8'h00; pulse_reset(); repeat (3) @(negedge clock);
    sw = 8'h05;
    repeat (17) @(negedge clock);
    chk("lat_before", 32'(level), 32'h00);
    @(negedge clock);
    chk("lat_at", 32'(level), 32'h05);
    do_read(4'h0, d, v); chk("lat_state", d, 32'h5);
    chk("b2b_valid0", 32'(v), 32'h1);
    do_read(4'h8, d, v); chk("lat_count", d, 32'h1);
    chk("b2b_valid1", 32'(v), 32'h1);
    @(negedge clock);
    chk("valid_drops", 32'(bus.rd_valid), 32'h0);
    chk("data_holds", bus.rd_data, 32'h1);

    // Bounce on bit 3: glitch never reaches level, final rise counted once.
    sw = 8'h00; pulse_reset(); repeat (3) @(negedge clock);
    sw = 8'h08; repeat (10) @(negedge clock);
    sw = 8'h00; repeat (3) @(negedge clock);
    sw = 8'h08;
    repeat (17) @(negedge clock);
    chk("bounce_before", 32'(level), 32'h00);
    @(negedge clock);
    chk("bounce_at", 32'(level), 32'h08);
    repeat (5) @(negedge clock);
    do_read(4'h8, d, v); chk("bounce_count", d, 32'h1);
    do_read(4'h4, d, v); chk("bounce_edges", d, 32'h8);

    // Rise of bit 1 on the same edge as an EDGES read stays pending.
    sw = 8'h00; pulse_reset(); repeat (3) @(negedge clock);
    sw = 8'h02;
    repeat (17) @(negedge clock);
    do_read(4'h4, d, v); chk("coinc_read1", d, 32'h0);
    chk("coinc_level", 32'(level), 32'h02);
    do_read(4'h4, d, v); chk("coinc_read2", d, 32'h2);

    // Reset mid-debounce, coinciding with a read.
    sw = 8'h00; pulse_reset(); repeat (3) @(negedge clock);
    sw = 8'hFF;
    repeat (10) @(negedge clock);
    reset = 1'b1; bus.rd = 1'b1; bus.addr = 4'h0;
    @(negedge clock);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    reset = 1'b0; bus.rd = 1'b0;
    repeat (17) @(negedge clock);
    chk("rstmid_before", 32'(level), 32'h00);
    @(negedge clock);
    chk("rstmid_at", 32'(level), 32'hFF);
    do_read(4'h4, d, v); chk("rstmid_edges", d, 32'hFF);
    do_read(4'h8, d, v); chk("rstmid_count", d, 32'h1);

    // Randomized run against the model.
    sw = 8'h00; pulse_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 23) == 0) sw[b] = ~sw[b];
      bus.rd   = $urandom_range(0, 1) == 1;
      bus.addr = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 999) == 0);
      @(negedge clock);
      chk("rand_level", 32'(level), 32'(m_level));
      chk("rand_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
      if (m_rd_valid) chk("rand_data", bus.rd_data, m_rd_data);
    end
    bus.rd = 1'b0; reset = 1'b0;

    // Counter wrap on the D=2 build: bits alternate so every edge carries one change.
    for (int k = 0; k < 32768; k++) begin
      sw2[0] = ~sw2[0];
      @(negedge clock);
      if (k != 32767) sw2[1] = ~sw2[1];
      @(negedge clock);
    end
    repeat (10) @(negedge clock);
    do_read2(4'h8, d, v); chk("wrap_ffff", d, 32'h0000_FFFF);
    chk("wrap_level2", 32'(level2), 32'h2);
    sw2[1] = ~sw2[1];
    repeat (10) @(negedge clock);
    do_read2(4'h8, d, v); chk("wrap_zero", d, 32'h0);
    do_read2(4'hC, d, v); chk("unmapped_data", d, 32'h0);
    chk("unmapped_valid", 32'(v), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
